mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that consumes CPU MMIO stores to the console address and serialises them onto the board's TX pin (8N1, LSB first).
- Sits downstream of the core's MMIO decode (mmio_oe/mmio_we/mem_addr/mem_wdata). In the simulation top it replaces the testbench `$write` peep as the real character sink.
- Reads of the same address return TX-ready status, so software can poll before writing.

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 149 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO constants and UART serialiser encoding used by the console
// transmitter and any future peripheral sitting behind the core's MMIO decode.
package mmio_pkg;

    localparam logic [31:0] MMIO_TX_ADDR     = 32'hf000_0100;
    localparam logic [31:0] MMIO_HALT_ADDR   = 32'hf000_0000;
    localparam int unsigned DEFAULT_BAUD_DIV = 868;  // 100 MHz / 115200

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Occupancy as reported in the 5-bit status field, clamped at 31.
    function automatic logic [4:0] count_sat5(input logic [31:0] count);
        return (count > 32'd31) ? 5'd31 : count[4:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered occupancy count; pushes while full
// and pops while empty are ignored, so callers may drive the strobes freely.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, and a resettable array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout = r_mem[r_rd_ptr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Console UART transmitter: MMIO stores to TX_ADDR queue a byte for 8N1
// serialisation, MMIO loads of the same address return FIFO status one cycle later.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] TX_ADDR    = MMIO_TX_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_oe,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        uart_txd,
    output logic        tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic        w_hit;
    logic        w_push;
    logic        w_rd;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [7:0]  w_head;
    logic        w_baud_done;
    logic        w_txd_next;
    logic        w_unused;

    uart_state_e   r_state;
    uart_state_e   w_state_next;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic          r_txd;
    logic          r_rvalid;
    logic [31:0]   r_rdata;

    // Only byte 0 carries the character; the upper store bytes are ignored.
    assign w_unused = ^mem_wdata[31:8];

    assign w_hit  = mmio_oe && (mem_addr == TX_ADDR);
    assign w_push = w_hit && mmio_we[0] && !w_full;
    assign w_rd   = w_hit && (mmio_we == 4'b0000);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Status port: fixed one-cycle read latency, no back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= {26'b0, count_sat5(32'(w_count)), !w_full};
        end
    end

    assign mem_rvalid = r_rvalid;
    assign mem_rdata  = r_rdata;

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= UART_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
        case (r_state)
            UART_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = UART_START;
                end
            end
            UART_START: begin
                w_txd_next = 1'b0;
                if (w_baud_done) w_state_next = UART_DATA;
            end
            UART_DATA: begin
                w_txd_next = r_shreg[0];
                if (w_baud_done && (r_bit_cnt == 3'd7)) w_state_next = UART_STOP;
            end
            UART_STOP: begin
                if (w_baud_done) w_state_next = UART_IDLE;
            end
            default: w_state_next = UART_IDLE;
        endcase
    end

    // Bit timing restarts on every state entry; within DATA it wraps per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else begin
            if ((w_state_next != r_state) || (r_state == UART_IDLE) || w_baud_done)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 1'b1;

            if (w_pop) begin
                r_shreg   <= w_head;
                r_bit_cnt <= '0;
            end else if ((r_state == UART_DATA) && w_baud_done) begin
                r_shreg   <= r_shreg >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // The pin comes straight from a flop so it never glitches on decode.
    always_ff @(posedge clk) begin
        if (rst) r_txd <= 1'b1;
        else     r_txd <= w_txd_next;
    end

    assign uart_txd = r_txd;
    assign tx_busy  = (w_count != '0) || (r_state != UART_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a cycle-arithmetic model predicts status
// reads, frame start times and busy; monitors decode the pin and the read port.
module tb_mmio_uart_tx;
    import mmio_pkg::*;

    localparam int B = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmio_oe = 1'b0;
    logic [3:0]  mmio_we = 4'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        uart_txd;
    logic        tx_busy;

    mmio_uart_tx #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D),
        .TX_ADDR    (MMIO_TX_ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_oe    (mmio_oe),
        .mmio_we    (mmio_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: every accepted byte has a push edge and a serialiser pop edge.
    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;
    typedef struct {
        logic [31:0] data;
        int          at;
    } rd_t;

    int     push_q[$];
    int     pop_q[$];
    int     last_pop = -100000;
    frame_t exp_frames[$];
    rd_t    exp_reads[$];

    function automatic int occ(input int k);
        int n = 0;
        foreach (push_q[i]) if (push_q[i] <= k) n++;
        foreach (pop_q[i])  if (pop_q[i] <= k)  n--;
        return n;
    endfunction

    function automatic logic busy_at(input int k);
        if (occ(k) > 0) return 1'b1;
        foreach (pop_q[i]) if (pop_q[i] <= k && k < pop_q[i] + 10 * B) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        push_q.delete();
        pop_q.delete();
        exp_frames.delete();
        exp_reads.delete();
        last_pop = -100000;
    endfunction

    task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
        int k;
        int n;
        int p;
        @(posedge clk); #1;
        k = cyc;
        mmio_oe   = 1'b1;
        mem_addr  = addr;
        mmio_we   = we;
        mem_wdata = wdata;
        if (!rst && addr == MMIO_TX_ADDR) begin
            n = occ(k);
            if (we == 4'b0000) begin
                exp_reads.push_back('{data: {26'b0, 5'((n > 31) ? 31 : n), (n < D) ? 1'b1 : 1'b0}, at: k + 1});
            end else if (we[0] && n < D) begin
                p = (k + 2 > last_pop + 10 * B + 1) ? k + 2 : last_pop + 10 * B + 1;
                push_q.push_back(k + 1);
                pop_q.push_back(p);
                last_pop = p;
                exp_frames.push_back('{data: wdata[7:0], start: p + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            mmio_oe  = 1'b0;
            mem_addr = MMIO_TX_ADDR;
            mmio_we  = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drain(input string name);
        int budget = 3000;
        idle(1);
        while ((exp_frames.size() != 0 || mon_active || exp_reads.size() != 0 || busy_at(cyc)) && budget > 0) begin
            idle(1);
            budget--;
        end
        check({name, "_drain_timeout"}, 32'(budget == 0), 0);
        idle(3);
    endtask

    // Line monitor: decodes frames and checks every bit-cycle of each one.
    logic       mon_active = 1'b0;
    int         mon_s;
    int         mon_k;
    int         mon_bad;
    logic [9:0] mon_bits;
    logic [7:0] mon_byte;
    frame_t     mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                mon_k = cyc - mon_s;
                if (uart_txd !== mon_bits[mon_k / B]) mon_bad++;
                if (mon_k / B >= 1 && mon_k / B <= 8 && mon_k % B == B / 2)
                    mon_byte[mon_k / B - 1] = uart_txd;
                if (mon_k == 10 * B - 1) begin
                    check("frame_byte", 32'(mon_byte), 32'(mon_exp.data));
                    check("frame_shape_errs", mon_bad, 0);
                    mon_active = 1'b0;
                end
            end else if (uart_txd === 1'b0) begin
                if (exp_frames.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    mon_exp    = exp_frames.pop_front();
                    check("frame_start_cycle", cyc, mon_exp.start);
                    mon_active = 1'b1;
                    mon_s      = cyc;
                    mon_bad    = 0;
                    mon_byte   = '0;
                    mon_bits   = {1'b1, mon_exp.data, 1'b0};
                end
            end
            check("tx_busy", 32'(tx_busy), 32'(busy_at(cyc)));
        end
    end

    // Read-port monitor.
    rd_t rd_exp;
    always @(negedge clk) begin
        if (!rst && mem_rvalid) begin
            if (exp_reads.size() == 0) begin
                check("unexpected_rvalid", 1, 0);
            end else begin
                rd_exp = exp_reads.pop_front();
                check("status_rdata", mem_rdata, rd_exp.data);
                check("status_latency", cyc, rd_exp.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        string msg;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", 32'(uart_txd), 1);
        check("reset_busy", 32'(tx_busy), 0);
        check("reset_rvalid", 32'(mem_rvalid), 0);
        check("reset_rdata", mem_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Status read with empty FIFO, then a single 0x55 frame.
        access(MMIO_TX_ADDR, 4'b0000, 32'h0);
        access(MMIO_TX_ADDR, 4'b0001, 32'hdead_be55);
        drain("basic");

        // Non-hit address and partial byte enables must do nothing.
        access(32'hf000_0104, 4'b0001, 32'h41);
        access(MMIO_TX_ADDR, 4'b0010, 32'h42);
        access(32'hf000_0104, 4'b0000, 32'h0);
        access(MMIO_TX_ADDR, 4'b0000, 32'h0);
        idle(60);
        drain("nonhit");

        // Overfill while the first byte is on the wire, then read status.
        for (int i = 0; i < 6; i++) access(MMIO_TX_ADDR, 4'b0001, 32'(8'h30 + i));
        access(MMIO_TX_ADDR, 4'b0000, 32'h0);
        drain("fill");

        // Ordering of a short string.
        access(MMIO_TX_ADDR, 4'b1111, 32'h48);
        access(MMIO_TX_ADDR, 4'b0001, 32'h69);
        access(MMIO_TX_ADDR, 4'b0001, 32'h0a);
        drain("order");

        // Reset during data bit 3 of the first frame with two bytes queued.
        access(MMIO_TX_ADDR, 4'b0001, 32'ha5);
        access(MMIO_TX_ADDR, 4'b0001, 32'h5a);
        access(MMIO_TX_ADDR, 4'b0001, 32'hc3);
        target = pop_q[pop_q.size() - 3] + 1 + 4 * B + 1;
        idle(1);
        while (cyc < target) idle(1);
        @(posedge clk); #1;
        rst = 1'b1;
        mmio_oe = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("midreset_txd", 32'(uart_txd), 1);
        check("midreset_busy", 32'(tx_busy), 0);
        check("midreset_rvalid", 32'(mem_rvalid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(MMIO_TX_ADDR, 4'b0000, 32'h0);
        drain("reset");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: access(MMIO_TX_ADDR, 4'($urandom_range(0, 15)) | 4'b0001, $urandom);
                4:          access(MMIO_TX_ADDR, 4'b0000, $urandom);
                5:          access(MMIO_TX_ADDR + 32'(4 * $urandom_range(1, 8)), 4'($urandom_range(0, 15)), $urandom);
                default:    idle(1);
            endcase
        end
        drain("random");

        check("leftover_frames", exp_frames.size(), 0);
        check("leftover_reads", exp_reads.size(), 0);

        msg = $sformatf("Result: errors=%0d of %0d checks", errors, checks);
        $display("%s", msg);
        $finish;
    end

endmodule
